bus_master: RTL and testbench
=============================

Name: bus_master

Overview:
- Synchronous 68030-protocol bus initiator. Takes a single-operand transfer request from a local client (DMA engine, debug port) and runs asynchronous bus cycles: nAS/nDS/RnW/SIZ out, nDSACK/nBERR back.
- Sits on the same bus as the DRAM controller and other DSACK-generating responders.
- Implements dynamic bus sizing: splits operands across 8-, 16- and 32-bit ports, and routes data lanes exactly as the 68030 does.

Parameters:
- TIMEOUT_CLKS, 255: clocks to wait for termination before self-generated bus error (8-bit counter).
- ADDR_W, 28: address width.

Ports:
- CLK in 1: system clock, 25 MHz.
- nRST in 1: asynchronous active-low reset.
- REQ in 1: start a transfer; sampled only in IDLE.
- REQ_RnW in 1: 1 = read, 0 = write.
- REQ_SIZE in 2: 68030 SIZ encoding; 01 byte, 10 word, 11 three-byte, 00 long.
- REQ_ADDR in ADDR_W: operand byte address, any alignment.
- REQ_WDATA in 32: write operand, right-justified.
- BUSY out 1: transfer in progress.
- DONE out 1: one-clock pulse when the transfer ends.
- ERR out 1: valid with DONE; 1 = bus error or timeout.
- RDATA out 32: read operand, right-justified, zero-filled; valid from DONE until the next REQ.
- ADDR out ADDR_W: bus address.
- SIZ1, SIZ0 out 1 each: remaining-byte count, 68030 encoding.
- RnW out 1: bus direction.
- nAS out 1: address strobe.
- nDS out 1: data strobe.
- D_OUT out 32: write data lanes.
- D_OE out 1: data bus output enable.
- D_IN in 32: read data lanes.
- nDSACK0, nDSACK1 in 1 each: asynchronous termination inputs.
- nBERR in 1: asynchronous bus error input.

Behaviour:
- Reset values: BUSY=0, DONE=0, ERR=0, RDATA=0, ADDR=0, SIZ=00, RnW=1, nAS=1, nDS=1, D_OE=0, D_OUT=0, FSM=IDLE. Reset asserted mid-cycle releases the strobes immediately (asynchronously).
- Input synchronisation: nDSACK0, nDSACK1 and nBERR each pass through a 2-flop synchroniser. All decisions use the synchronised values.
- Internal state:
  - CNT (3 bits): remaining bytes, 1..4.
  - A: current address.
  - OP: remaining operand bytes, left-aligned; OP0 is the most significant remaining byte.
- FSM states: IDLE, ADR, STRB, WAIT, TERM, DONE_S.
  - IDLE: on REQ, latch the request, set BUSY=1, go to ADR.
  - ADR: drive ADDR=A, SIZ=CNT mod 4, RnW; if write, D_OE=1 and drive D_OUT. Go to STRB.
  - STRB: nAS=0; nDS=0 on reads. Go to WAIT.
  - WAIT: nDS=0 on writes (one clock after nAS). Exit conditions:
    - sync nBERR=0 -> TERM with error.
    - either sync nDSACK=0 -> TERM.
    - timeout counter reaches TIMEOUT_CLKS -> TERM with error.
    - nBERR takes priority over DSACK when both are seen in the same clock.
  - TERM: on reads, capture bytes. Deassert nAS, nDS, D_OE. Advance A and CNT by n (bytes transferred); shift OP left by n bytes.
    - Error, or CNT reaches 0 -> DONE_S.
    - Otherwise wait until both sync nDSACK are high again, then go to ADR.
  - DONE_S: DONE=1 for one clock, BUSY=0, return to IDLE.
- Timeout counter: cleared on entry to STRB; counts in WAIT.
- Port size, from sync {nDSACK1, nDSACK0}:
  - 00 -> 32-bit port, n = min(CNT, 4 - A[1:0]).
  - 01 -> 16-bit port, n = min(CNT, 2 - A[0]).
  - 10 -> 8-bit port, n = 1.
- Write lane routing (A = A[1:0]):
  - D31:24 = OP0.
  - D23:16 = A[0] ? OP0 : OP1.
  - D15:8 = (A==10) ? OP0 : (A==00) ? OP2 : OP1.
  - D7:0 = (A==11) ? OP0 : (A==10) ? OP1 : (A==01) ? OP2 : OP3.
- Read capture: the byte for offset k (0..n-1) comes from:
  - 32-bit port: lane 3 - ((A+k) mod 4).
  - 16-bit port: lane 3 - ((A+k) mod 2).
  - 8-bit port: lane 3.
  - Lane 3 = D31:24.
- Read assembly: bytes are appended in order. At DONE, RDATA is right-justified to the request size. On error, RDATA holds the bytes captured so far, right-justified.
- Address arithmetic: ADDR wraps modulo 2^ADDR_W.
- REQ while BUSY is ignored.

Test Plan:
- Long read at 0x0000100, responder gives 32-bit DSACK (both low) with D_IN=0xDEADBEEF -> one bus cycle, SIZ=00; DONE with RDATA=0xDEADBEEF, ERR=0.
- Long write of 0x11223344 at 0x0000001, 32-bit port -> cycle 1: ADDR=..01, SIZ=00, D_OUT=0x11112233, n=3. Cycle 2: ADDR=..04, SIZ=01, D31:24=0x44. DONE, ERR=0.
- Word read at 0x0000002, 8-bit port (nDSACK0 only), bytes 0xAB then 0xCD on D31:24 -> two cycles, SIZ=10 then 01; RDATA=0x0000ABCD.
- Long read at 0x0000000, 16-bit port returning 0x1234xxxx then 0x5678xxxx -> two cycles at ADDR 0 and 2; RDATA=0x12345678.
- Responder never terminates -> TIMEOUT_CLKS+1 clocks in WAIT; DONE with ERR=1; nAS high afterwards. Separately: nBERR and nDSACK asserted together -> ERR=1.
- nRST pulsed low during WAIT -> nAS, nDS, D_OE release immediately; BUSY=0; no DONE pulse; the next REQ runs normally.

Source files
------------

// File: rtl/bus_master.sv
// 68030-protocol bus initiator with dynamic bus sizing.
// A single client operand is split into one or more asynchronous bus cycles.
// Each cycle is sized by the responder's DSACK encoding, and the bytes are
// routed onto the data lanes the way the 68030 routes them.
module bus_master #(
  parameter int TIMEOUT_CLKS = 255,
  parameter int ADDR_W       = 28
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              REQ,
  input  logic              REQ_RnW,
  input  logic [1:0]        REQ_SIZE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [31:0]       RDATA,
  output logic [ADDR_W-1:0] ADDR,
  output logic              SIZ1,
  output logic              SIZ0,
  output logic              RnW,
  output logic              nAS,
  output logic              nDS,
  output logic [31:0]       D_OUT,
  output logic              D_OE,
  input  logic [31:0]       D_IN,
  input  logic              nDSACK0,
  input  logic              nDSACK1,
  input  logic              nBERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADR, S_STRB, S_WAIT, S_TERM, S_DONE
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT_CLKS);

  // 68030 write lane routing: OP0 is the most significant remaining byte.
  function automatic logic [31:0] route(input logic [31:0] op, input logic [1:0] a);
    logic [7:0] b0, b1, b2, b3;
    logic [31:0] d;
    b0 = op[31:24];
    b1 = op[23:16];
    b2 = op[15:8];
    b3 = op[7:0];
    d[31:24] = b0;
    d[23:16] = a[0] ? b0 : b1;
    d[15:8]  = (a == 2'b10) ? b0 : (a == 2'b00) ? b2 : b1;
    d[7:0]   = (a == 2'b11) ? b0 : (a == 2'b10) ? b1 : (a == 2'b01) ? b2 : b3;
    return d;
  endfunction

  // Synchronised termination inputs: bit 0 nDSACK0, bit 1 nDSACK1, bit 2 nBERR
  logic [2:0] async_in, sync1_q, sync2_q;
  assign async_in = {nBERR, nDSACK1, nDSACK0};

  for (genvar i = 0; i < 3; i++) begin : g_sync
    // Two-flop synchroniser per asynchronous input; idles released (high).
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        sync1_q[i] <= 1'b1;
        sync2_q[i] <= 1'b1;
      end else begin
        sync1_q[i] <= async_in[i];
        sync2_q[i] <= sync1_q[i];
      end
    end
  end

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [31:0]         op_q, op_d;
  logic                rnw_q, rnw_d;
  logic [31:0]         rbuf_q, rbuf_d;
  logic [1:0]          portsz_q, portsz_d;
  logic [7:0]          tmo_q, tmo_d;
  logic                err_q, err_d;
  logic                adv_q, adv_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                errout_q, errout_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          siz_q, siz_d;
  logic                rnwo_q, rnwo_d;
  logic                nas_q, nas_d;
  logic                nds_q, nds_d;
  logic                doe_q, doe_d;
  logic [31:0]         dout_q, dout_d;

  logic [2:0]          n;
  logic [31:0]         cap;
  logic                enter_adr, enter_done, term;

  // Bytes moved by the current cycle, from the latched port size.
  always_comb begin
    logic [2:0] room32, room16;
    room32 = 3'd4 - {1'b0, a_q[1:0]};
    room16 = 3'd2 - {2'b00, a_q[0]};
    case (portsz_q)
      2'b00:   n = (cnt_q < room32) ? cnt_q : room32;
      2'b01:   n = (cnt_q < room16) ? cnt_q : room16;
      default: n = 3'd1;
    endcase
  end

  // Read assembly: append the n bytes of this cycle in address order.
  always_comb begin
    logic [1:0] off, lane;
    cap = rbuf_q;
    for (int k = 0; k < 4; k++) begin
      off = a_q[1:0] + 2'(k);
      case (portsz_q)
        2'b00:   lane = 2'd3 - off;
        2'b01:   lane = 2'd3 - {1'b0, off[0]};
        default: lane = 2'd3;
      endcase
      if (3'(k) < n) cap = {cap[23:0], D_IN[{lane, 3'b000} +: 8]};
    end
  end

  // Next-state and output-register logic of the bus-cycle FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    op_d     = op_q;
    rnw_d    = rnw_q;
    rbuf_d   = rbuf_q;
    portsz_d = portsz_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    adv_d    = adv_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    errout_d = 1'b0;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    siz_d    = siz_q;
    rnwo_d   = rnwo_q;
    nas_d    = nas_q;
    nds_d    = nds_q;
    doe_d    = doe_q;
    dout_d   = dout_q;
    enter_adr  = 1'b0;
    enter_done = 1'b0;
    term       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          a_d    = REQ_ADDR;
          rnw_d  = REQ_RnW;
          rbuf_d = '0;
          err_d  = 1'b0;
          busy_d = 1'b1;
          // Left-align the right-justified operand so OP0 is the first byte out.
          case (REQ_SIZE)
            2'b01:   begin cnt_d = 3'd1; op_d = {REQ_WDATA[7:0],  24'h0}; end
            2'b10:   begin cnt_d = 3'd2; op_d = {REQ_WDATA[15:0], 16'h0}; end
            2'b11:   begin cnt_d = 3'd3; op_d = {REQ_WDATA[23:0],  8'h0}; end
            default: begin cnt_d = 3'd4; op_d = REQ_WDATA;               end
          endcase
          state_d   = S_ADR;
          enter_adr = 1'b1;
        end
      end
      S_ADR: begin
        nas_d   = 1'b0;
        nds_d   = ~rnw_q;  // reads strobe data together with the address
        tmo_d   = '0;
        state_d = S_STRB;
      end
      S_STRB: begin
        nds_d   = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        term = 1'b1;
        if (!sync2_q[2]) begin
          err_d = 1'b1;  // bus error wins over a simultaneous DSACK
        end else if (!sync2_q[0] || !sync2_q[1]) begin
          portsz_d = sync2_q[1:0];
        end else if (tmo_q == TMO) begin
          err_d = 1'b1;
        end else begin
          term  = 1'b0;
          tmo_d = tmo_q + 8'd1;
        end
        if (term) begin
          state_d = S_TERM;
          nas_d   = 1'b1;
          nds_d   = 1'b1;
          doe_d   = 1'b0;
          adv_d   = 1'b0;
        end
      end
      S_TERM: begin
        if (!adv_q) begin
          // First TERM clock: account for the bytes this cycle moved.
          adv_d = 1'b1;
          if (err_q) begin
            enter_done = 1'b1;
          end else begin
            if (rnw_q) rbuf_d = cap;
            a_d   = a_q + ADDR_W'(n);
            cnt_d = cnt_q - n;
            op_d  = op_q << {n, 3'b000};
            if (cnt_q == n) enter_done = 1'b1;
          end
        end else if (sync2_q[1:0] == 2'b11) begin
          // Responder has released DSACK; start the next piece.
          state_d   = S_ADR;
          enter_adr = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (enter_adr) begin
      addr_d = a_d;
      siz_d  = cnt_d[1:0];
      rnwo_d = rnw_d;
      doe_d  = ~rnw_d;
      dout_d = rnw_d ? 32'h0 : route(op_d, a_d[1:0]);
    end

    if (enter_done) begin
      state_d  = S_DONE;
      done_d   = 1'b1;
      errout_d = err_q;
      busy_d   = 1'b0;
      rdata_d  = rbuf_d;
      rnwo_d   = 1'b1;
    end
  end

  // State and bus-output registers; reset drops the strobes at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      op_q     <= '0;
      rnw_q    <= 1'b1;
      rbuf_q   <= '0;
      portsz_q <= 2'b11;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      adv_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      errout_q <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      siz_q    <= 2'b00;
      rnwo_q   <= 1'b1;
      nas_q    <= 1'b1;
      nds_q    <= 1'b1;
      doe_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      op_q     <= op_d;
      rnw_q    <= rnw_d;
      rbuf_q   <= rbuf_d;
      portsz_q <= portsz_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      adv_q    <= adv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      errout_q <= errout_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      siz_q    <= siz_d;
      rnwo_q   <= rnwo_d;
      nas_q    <= nas_d;
      nds_q    <= nds_d;
      doe_q    <= doe_d;
      dout_q   <= dout_d;
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign ERR   = errout_q;
  assign RDATA = rdata_q;
  assign ADDR  = addr_q;
  assign SIZ1  = siz_q[1];
  assign SIZ0  = siz_q[0];
  assign RnW   = rnwo_q;
  assign nAS   = nas_q;
  assign nDS   = nds_q;
  assign D_OUT = dout_q;
  assign D_OE  = doe_q;

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: a behavioural 68030 responder backed by a 64-byte
// memory, directed scenarios and randomized transfers checked against a
// byte-level model of what the operand should look like in memory.
module tb_bus_master;

  localparam int AW = 28;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          REQ, REQ_RnW;
  logic [1:0]    REQ_SIZE;
  logic [AW-1:0] REQ_ADDR;
  logic [31:0]   REQ_WDATA;
  logic          BUSY, DONE, ERR;
  logic [31:0]   RDATA;
  logic [AW-1:0] ADDR;
  logic          SIZ1, SIZ0, RnW, nAS, nDS;
  logic [31:0]   D_OUT;
  logic          D_OE;
  logic [31:0]   D_IN;
  logic          nDSACK0, nDSACK1, nBERR;

  bus_master #(.TIMEOUT_CLKS(255), .ADDR_W(AW)) dut (
    .CLK(CLK), .nRST(nRST), .REQ(REQ), .REQ_RnW(REQ_RnW), .REQ_SIZE(REQ_SIZE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR), .RDATA(RDATA), .ADDR(ADDR), .SIZ1(SIZ1), .SIZ0(SIZ0), .RnW(RnW),
    .nAS(nAS), .nDS(nDS), .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN),
    .nDSACK0(nDSACK0), .nDSACK1(nDSACK1), .nBERR(nBERR)
  );

  always #20 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- responder ----------------
  typedef struct {
    int          addr;
    logic [1:0]  siz;
    logic [31:0] dout;
    logic        rnw;
  } cyc_t;

  cyc_t       log_q[$];
  logic [7:0] mem[64];
  logic [7:0] exp_mem[64];
  int         resp_ps   = 0;  // 0:32-bit 1:16-bit 2:8-bit 3:never answers
  bit         resp_berr = 0;
  int         resp_dly  = 0;
  int         nas_cnt   = 0;
  bit         in_cyc    = 0;
  bit         acked     = 0;
  int         wcnt      = 0;

  task automatic do_access();
    cyc_t c;
    int a, cnt, lo, hi, base;
    logic [31:0] d;
    c.addr = int'(ADDR);
    c.siz  = {SIZ1, SIZ0};
    c.dout = D_OUT;
    c.rnw  = RnW;
    log_q.push_back(c);
    a   = int'(ADDR);
    cnt = (c.siz == 2'b00) ? 4 : int'(c.siz);
    if (resp_berr) begin
      nBERR = 1'b0;
    end else if (RnW) begin
      d = $urandom();
      case (resp_ps)
        0: begin base = a & ~3; for (int o = 0; o < 4; o++) d[(3-o)*8 +: 8] = mem[(base+o) & 63]; end
        1: begin base = a & ~1; for (int o = 0; o < 2; o++) d[(3-o)*8 +: 8] = mem[(base+o) & 63]; end
        default: d[31:24] = mem[a & 63];
      endcase
      D_IN = d;
    end else begin
      case (resp_ps)
        0: begin
          lo = a & 3; hi = lo + cnt - 1; if (hi > 3) hi = 3;
          for (int o = lo; o <= hi; o++) mem[(a+o-lo) & 63] = D_OUT[(3-o)*8 +: 8];
        end
        1: begin
          lo = a & 1; hi = lo + cnt - 1; if (hi > 1) hi = 1;
          for (int o = lo; o <= hi; o++) mem[(a+o-lo) & 63] = D_OUT[(3-o)*8 +: 8];
        end
        default: mem[a & 63] = D_OUT[31:24];
      endcase
    end
    case (resp_ps)
      0: begin nDSACK1 = 1'b0; nDSACK0 = 1'b0; end
      1: nDSACK1 = 1'b0;
      default: nDSACK0 = 1'b0;
    endcase
  endtask

  initial begin
    nDSACK0 = 1'b1; nDSACK1 = 1'b1; nBERR = 1'b1; D_IN = '0;
    forever begin
      @(negedge CLK);
      if (nAS !== 1'b0) begin
        nDSACK0 = 1'b1; nDSACK1 = 1'b1; nBERR = 1'b1;
        in_cyc = 0; acked = 0;
      end else begin
        if (!in_cyc) begin in_cyc = 1; wcnt = 0; end
        nas_cnt++;
        if (!acked && resp_ps < 3 && wcnt >= resp_dly) begin
          acked = 1;
          do_access();
        end
        wcnt++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic set_mem(input int idx, input logic [7:0] b);
    mem[idx & 63]     = b;
    exp_mem[idx & 63] = b;
  endtask

  task automatic xfer(input bit rnw, input logic [1:0] sz, input int addr,
                      input logic [31:0] wd, input int ps, input bit berr,
                      output logic [31:0] rd, output logic er);
    bit got;
    resp_ps = ps; resp_berr = berr; resp_dly = $urandom_range(0, 3);
    log_q.delete(); nas_cnt = 0;
    @(negedge CLK);
    REQ = 1'b1; REQ_RnW = rnw; REQ_SIZE = sz; REQ_ADDR = AW'(addr); REQ_WDATA = wd;
    @(negedge CLK);
    REQ = 1'b0;
    chk("busy_during", BUSY, 1'b1);
    got = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge CLK);
      if (i == 2) begin  // a request while busy must be ignored
        REQ = 1'b1; REQ_RnW = ~rnw; REQ_SIZE = $urandom(); REQ_ADDR = $urandom(); REQ_WDATA = $urandom();
      end
      if (i == 3) REQ = 1'b0;
      if (DONE === 1'b1) got = 1;
    end
    REQ = 1'b0;
    chk("done_seen", got, 1'b1);
    rd = RDATA;
    er = ERR;
    chk("busy_at_done", BUSY, 1'b0);
    @(negedge CLK);
    chk("done_one_clk", DONE, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd, wd, exp;
  logic        er;
  int          addr, c, ps, w, nbad;
  bit          rnw;
  logic [1:0]  sz;
  bit          seen;

  initial begin
    nRST = 1'b0; REQ = 1'b0; REQ_RnW = 1'b1; REQ_SIZE = 2'b00; REQ_ADDR = '0; REQ_WDATA = '0;
    for (int i = 0; i < 64; i++) set_mem(i, 8'($urandom()));
    repeat (3) @(negedge CLK);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_err", ERR, 1'b0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_addr", ADDR, 28'h0);
    chk("rst_siz", {SIZ1, SIZ0}, 2'b00);
    chk("rst_strobes", {RnW, nAS, nDS, D_OE}, 4'b1110);
    chk("rst_dout", D_OUT, 32'h0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Long read, 32-bit port
    set_mem(0, 8'hDE); set_mem(1, 8'hAD); set_mem(2, 8'hBE); set_mem(3, 8'hEF);
    xfer(1, 2'b00, 32'h100, 32'h0, 0, 0, rd, er);
    chk("t1_rdata", rd, 32'hDEADBEEF);
    chk("t1_err", er, 1'b0);
    chk("t1_cycles", log_q.size(), 1);
    if (log_q.size() == 1) chk("t1_siz", log_q[0].siz, 2'b00);

    // Long write, misaligned, 32-bit port
    xfer(0, 2'b00, 1, 32'h11223344, 0, 0, rd, er);
    for (int i = 0; i < 4; i++) exp_mem[1+i] = 8'(32'h11223344 >> (8*(3-i)));
    chk("t2_err", er, 1'b0);
    chk("t2_cycles", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t2_c1", {log_q[0].addr, 30'(log_q[0].siz), log_q[0].dout}, {32'd1, 30'd0, 32'h11112233});
      chk("t2_c2", {log_q[1].addr, 30'(log_q[1].siz), 24'h0, log_q[1].dout[31:24]}, {32'd4, 30'd1, 32'h44});
    end
    chk("t2_mem", {mem[1], mem[2], mem[3], mem[4]}, 32'h11223344);

    // Word read, 8-bit port
    set_mem(2, 8'hAB); set_mem(3, 8'hCD);
    xfer(1, 2'b10, 2, 32'h0, 2, 0, rd, er);
    chk("t3_rdata", rd, 32'h0000ABCD);
    chk("t3_cycles", log_q.size(), 2);
    if (log_q.size() == 2) chk("t3_sizes", {log_q[0].siz, log_q[1].siz}, 4'b1001);

    // Long read, 16-bit port
    set_mem(0, 8'h12); set_mem(1, 8'h34); set_mem(2, 8'h56); set_mem(3, 8'h78);
    xfer(1, 2'b00, 0, 32'h0, 1, 0, rd, er);
    chk("t4_rdata", rd, 32'h12345678);
    if (log_q.size() == 2) chk("t4_addrs", {log_q[0].addr, log_q[1].addr}, {32'd0, 32'd2});
    else chk("t4_cycles", log_q.size(), 2);

    // Responder never answers: self-generated bus error
    xfer(1, 2'b00, 8, 32'h0, 3, 0, rd, er);
    chk("t5_err", er, 1'b1);
    chk("t5_nas_low_clks", nas_cnt, 255 + 2);
    chk("t5_nas_high", nAS, 1'b1);
    chk("t5_rdata", rd, 32'h0);

    // nBERR together with DSACK
    xfer(1, 2'b10, 4, 32'h0, 0, 1, rd, er);
    chk("t6_err", er, 1'b1);
    chk("t6_rdata", rd, 32'h0);

    // Reset mid-cycle
    resp_ps = 3;
    @(negedge CLK);
    REQ = 1'b1; REQ_RnW = 1'b0; REQ_SIZE = 2'b00; REQ_ADDR = 28'd8; REQ_WDATA = 32'hCAFEF00D;
    @(negedge CLK);
    REQ = 1'b0;
    repeat (8) @(negedge CLK);
    chk("t7_pre", {nAS, nDS, D_OE}, 3'b001);
    #5 nRST = 1'b0;
    #1;
    chk("t7_release", {nAS, nDS, D_OE, BUSY}, 4'b1100);
    @(negedge CLK);
    nRST = 1'b1;
    seen = 0;
    repeat (6) begin @(negedge CLK); if (DONE === 1'b1) seen = 1; end
    chk("t7_no_done", seen, 1'b0);
    set_mem(8, 8'h01); set_mem(9, 8'h02); set_mem(10, 8'h03); set_mem(11, 8'h04);
    xfer(1, 2'b00, 8, 32'h0, 0, 0, rd, er);
    chk("t7_after", {er, rd}, {1'b0, 32'h01020304});

    // Randomized transfers against the byte-level model
    for (int t = 0; t < 40; t++) begin
      rnw  = $urandom_range(0, 1);
      sz   = 2'($urandom());
      ps   = $urandom_range(0, 2);
      addr = ($urandom_range(0, 4) == 0) ? 32'h0FFFFFFC + $urandom_range(0, 3) : $urandom_range(0, 63);
      wd   = $urandom();
      c    = (sz == 2'b00) ? 4 : int'(sz);
      w    = (ps == 0) ? 4 : (ps == 1) ? 2 : 1;
      xfer(rnw, sz, addr, wd, ps, 0, rd, er);
      chk("rnd_err", er, 1'b0);
      chk("rnd_cycles", log_q.size(), (addr + c - 1) / w - addr / w + 1);
      if (rnw) begin
        exp = 0;
        for (int i = 0; i < c; i++) exp = (exp << 8) | 32'(exp_mem[(addr + i) & 63]);
        chk("rnd_rdata", rd, exp);
      end else begin
        for (int i = 0; i < c; i++) exp_mem[(addr + i) & 63] = wd[(c-1-i)*8 +: 8];
        nbad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) nbad++;
        chk("rnd_wmem", nbad, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
